// File: rtl/matmul_result_display.sv
// matmul_result_display: accepts one 2x2 result frame and time-multiplexes its four sums onto one seven-segment digit.
// Optional ERROR_DISPLAY_EN: a frame captured with err_in set shows 'E' in every slot.
module matmul_result_display #(
    parameter int DWELL_CYCLES = 1000,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       res_valid,
    output logic       res_ready,
    input  logic [7:0] res_hi,
    input  logic [7:0] res_lo,
    input  logic       err_in,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] idx,
    output logic       busy,
    output logic       done
);
    typedef enum logic {IDLE, SHOW} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [1:0]       idx_d;
    logic             done_d;
    logic [7:0]       hi_q, lo_q;
    logic [3:0]       nib;
    logic             err_show;
    logic             xfer;
    logic             last;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    assign res_ready = (state == IDLE) && ena && rst_n;
    assign xfer      = res_valid && res_ready;
    assign last      = cnt == LAST;
    assign busy      = state == SHOW;

`ifdef ERROR_DISPLAY_EN
    logic err_q;
    always_ff @(posedge clk)
        if (!rst_n) err_q <= 1'b0;
        else if (xfer) err_q <= err_in;
    assign err_show = err_q;
`else
    logic unused_err;
    assign unused_err = err_in;
    assign err_show   = 1'b0;
`endif

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        done_d  = 1'b0;
        if (state == IDLE) begin
            if (xfer) begin
                state_d = SHOW;
                cnt_d   = '0;
                idx_d   = '0;
            end
        end else if (ena) begin
            cnt_d = last ? '0 : cnt + 1'b1;
            if (last) begin
                idx_d = idx + 1'b1;
                if (idx == 2'd3) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            done  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (xfer) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
        end
    end

    assign nib = idx == 2'd0 ? hi_q[7:4] : idx == 2'd1 ? hi_q[3:0] : idx == 2'd2 ? lo_q[7:4] : lo_q[3:0];
    assign seg = !busy ? 7'h00 : err_show ? 7'h79 : glyph(nib);
    assign dp  = busy && idx == 2'd0 && !err_show;
endmodule

// File: tb/tb_matmul_result_display.sv
// tb_matmul_result_display: two instances (dwell 4 and dwell 1) checked every cycle against a frame-position reference model.
module tb_matmul_result_display;
    localparam int DW [2] = '{4, 1};
    localparam logic [6:0] GL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic clk = 1'b0, rst_n, ena, res_valid, err_in;
    logic [7:0] res_hi, res_lo;
    logic [1:0][6:0] seg_o;
    logic [1:0][1:0] idx_o;
    logic [1:0] ready_o, dp_o, busy_o, done_o;
    int checks = 0, errors = 0;

    logic       m_act [2];
    int         m_pos [2];
    logic [7:0] m_hi [2], m_lo [2];
    logic       m_err [2], m_done [2];

    always #5 clk = ~clk;

    matmul_result_display #(.DWELL_CYCLES(4), .CNT_W(3)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .res_valid(res_valid), .res_ready(ready_o[0]),
        .res_hi(res_hi), .res_lo(res_lo), .err_in(err_in), .seg(seg_o[0]), .dp(dp_o[0]),
        .idx(idx_o[0]), .busy(busy_o[0]), .done(done_o[0]));

    matmul_result_display #(.DWELL_CYCLES(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .res_valid(res_valid), .res_ready(ready_o[1]),
        .res_hi(res_hi), .res_lo(res_lo), .err_in(err_in), .seg(seg_o[1]), .dp(dp_o[1]),
        .idx(idx_o[1]), .busy(busy_o[1]), .done(done_o[1]));

    // Model: a frame is just a count of ena-high cycles elapsed since its capture.
    always @(posedge clk)
        for (int k = 0; k < 2; k++) begin
            m_done[k] <= 1'b0;
            if (!rst_n) begin
                m_act[k] <= 1'b0;
                m_pos[k] <= 0;
            end else if (!m_act[k]) begin
                if (res_valid && ena) begin
                    m_act[k] <= 1'b1;
                    m_pos[k] <= 0;
                    m_hi[k]  <= res_hi;
                    m_lo[k]  <= res_lo;
                    m_err[k] <= err_in;
                end
            end else if (ena) begin
                if (m_pos[k] == 4 * DW[k] - 1) begin
                    m_act[k]  <= 1'b0;
                    m_pos[k]  <= 0;
                    m_done[k] <= 1'b1;
                end else m_pos[k] <= m_pos[k] + 1;
            end
        end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            int slot, nib, eseg;
            logic eshow;
            logic [15:0] fr;
            slot = m_act[k] ? m_pos[k] / DW[k] : 0;
            fr   = {m_hi[k], m_lo[k]};
            nib  = int'((fr >> (12 - 4 * slot)) & 16'hF);
`ifdef ERROR_DISPLAY_EN
            eshow = m_act[k] && m_err[k];
`else
            eshow = 1'b0;
`endif
            eseg = !m_act[k] ? 0 : eshow ? 'h79 : int'(GL[nib]);
            check($sformatf("seg%0d", k), int'(seg_o[k]), eseg);
            check($sformatf("dp%0d", k), int'(dp_o[k]), int'(m_act[k] && slot == 0 && !eshow));
            check($sformatf("idx%0d", k), int'(idx_o[k]), slot);
            check($sformatf("busy%0d", k), int'(busy_o[k]), int'(m_act[k]));
            check($sformatf("done%0d", k), int'(done_o[k]), int'(m_done[k]));
            check($sformatf("ready%0d", k), int'(ready_o[k]), int'(!m_act[k] && ena && rst_n));
        end
    endtask

    task automatic send(input logic [7:0] hi, input logic [7:0] lo, input logic err);
        res_valid = 1'b1;
        res_hi    = hi;
        res_lo    = lo;
        err_in    = err;
        tick();
        res_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; res_valid = 1'b0; res_hi = '0; res_lo = '0; err_in = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        // Basic frame, then valid held with new data through SHOW
        res_valid = 1'b1; res_hi = 8'h85; res_lo = 8'h23;
        tick();
        res_hi = 8'h11; res_lo = 8'h11;
        repeat (20) tick();
        res_valid = 1'b0;
        repeat (20) tick();
        // Reset mid-frame
        send(8'h85, 8'h23, 1'b0);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        // Enable gap inside slot 1, then ena low while idle
        send(8'h85, 8'h23, 1'b0);
        repeat (5) tick();
        ena = 1'b0;
        repeat (3) tick();
        ena = 1'b1;
        repeat (16) tick();
        ena = 1'b0;
        res_valid = 1'b1;
        repeat (3) tick();
        res_valid = 1'b0;
        ena = 1'b1;
        tick();
        send(8'h00, 8'h48, 1'b0);
        repeat (20) tick();
        send(8'h12, 8'h34, 1'b1);
        repeat (20) tick();
        send(8'h9A, 8'hBF, 1'b0);
        repeat (20) tick();
        for (int i = 0; i < 3000; i++) begin
            res_valid = $urandom_range(0, 1) == 1;
            res_hi    = 8'($urandom);
            res_lo    = 8'($urandom);
            err_in    = $urandom_range(0, 3) == 0;
            ena       = $urandom_range(0, 9) != 0;
            rst_n     = $urandom_range(0, 99) != 0;
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
